// File: rtl/blink_fader_if.sv
// Signal bundle between an upstream blinker and blink_fader.
// Carries the on/off request and period strobe in, and the LED drive and status out.
interface blink_fader_if #(
  parameter int unsigned PWM_BITS = 8
);

  logic                led_in;
  logic                flg_in;
  logic                pwm_out;
  logic [PWM_BITS-1:0] level;
  logic                busy;
  logic [15:0]         flg_cnt;

  // Upstream side: drives requests, observes the fader.
  modport master (
    output led_in,
    output flg_in,
    input  pwm_out,
    input  level,
    input  busy,
    input  flg_cnt
  );

  // Fader side.
  modport slave (
    input  led_in,
    input  flg_in,
    output pwm_out,
    output level,
    output busy,
    output flg_cnt
  );

endinterface

// File: rtl/blink_fader.sv
// LED fader: turns the upstream on/off request into a brightness ramp and a PWM drive,
// and counts the upstream period strobes.
// Optional build macro BLINK_FADER_SYNC_EN: passes led_in through a two-flop synchroniser
// (two extra cycles of request latency). flg_in is never synchronised.
// The interface instance must be built with the same PWM_BITS as this module.
module blink_fader #(
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 16
) (
  input  logic         clk,
  input  logic         rst,
  blink_fader_if.slave bus
);

  localparam int unsigned PresW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PresW-1:0] PresMax = PresW'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0] LvlMax = '1;
  localparam logic [PWM_BITS-1:0] LvlMin = '0;

  typedef enum logic [1:0] {
    StOff,
    StRampUp,
    StOn,
    StRampDown
  } state_e;

  state_e              state_q, state_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  logic [PresW-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                pwm_out_q, pwm_out_d;
  logic [15:0]         flg_cnt_q, flg_cnt_d;

  logic led_s;
  logic ramp;
  logic step_tick;
  logic busy;

`ifdef BLINK_FADER_SYNC_EN
  logic [1:0] sync_q, sync_d;

  // Shift the raw request through two flops before the FSM sees it.
  always_comb begin
    sync_d = {sync_q[0], bus.led_in};
  end

  // Synchroniser flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign led_s = sync_q[1];
`else
  assign led_s = bus.led_in;
`endif

  assign ramp      = (state_q == StRampUp) || (state_q == StRampDown);
  assign step_tick = ramp && (presc_q == PresMax);

  // Brightness step: only on a tick, only when still heading the same way, saturating.
  // A reversal edge leaves the level untouched so the new ramp starts where the old one stopped.
  always_comb begin
    level_d = level_q;
    if (step_tick) begin
      if ((state_q == StRampUp) && led_s && (level_q != LvlMax)) begin
        level_d = level_q + 1'b1;
      end else if ((state_q == StRampDown) && !led_s && (level_q != LvlMin)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StOff;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a ramp ends on the same edge its level reaches the end stop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StOff: begin
        if (led_s) state_d = StRampUp;
      end
      StRampUp: begin
        if (!led_s) begin
          state_d = StRampDown;
        end else if (step_tick && (level_d == LvlMax)) begin
          state_d = StOn;
        end
      end
      StOn: begin
        if (!led_s) state_d = StRampDown;
      end
      StRampDown: begin
        if (led_s) begin
          state_d = StRampUp;
        end else if (step_tick && (level_d == LvlMin)) begin
          state_d = StOff;
        end
      end
      default: state_d = StOff;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy = ramp;
  end

  // Step prescaler: restarts on every state entry (reversals included), idles outside ramps.
  always_comb begin
    presc_d = presc_q;
    if ((state_d != state_q) || !ramp || step_tick) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + 1'b1;
    end
  end

  // PWM counter wraps naturally; the end stops force a steady level with no glitch pulse.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    if (level_q == LvlMax) begin
      pwm_out_d = 1'b1;
    end else if (level_q == LvlMin) begin
      pwm_out_d = 1'b0;
    end else begin
      pwm_out_d = (pwm_cnt_q < level_q);
    end
  end

  // Strobe counter, independent of the fade path; wraps at 16 bits.
  always_comb begin
    flg_cnt_d = flg_cnt_q;
    if (bus.flg_in) begin
      flg_cnt_d = flg_cnt_q + 16'd1;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_q   <= '0;
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
      flg_cnt_q <= '0;
    end else begin
      level_q   <= level_d;
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
      flg_cnt_q <= flg_cnt_d;
    end
  end

  assign bus.level   = level_q;
  assign bus.busy    = busy;
  assign bus.pwm_out = pwm_out_q;
  assign bus.flg_cnt = flg_cnt_q;

endmodule

// File: tb/tb_blink_fader.sv
// Scoreboard bench for blink_fader (PWM_BITS=8, STEP_DIV=4). The driver applies inputs on the
// falling edge, advances a behavioural model and queues the expected post-edge outputs; the
// monitor pops and compares just after each rising edge.
module tb_blink_fader;

  localparam int PwmBits = 8;
  localparam int StepDiv = 4;
  localparam int Max     = (1 << PwmBits) - 1;
`ifdef BLINK_FADER_SYNC_EN
  localparam int Lat = 2;
`else
  localparam int Lat = 0;
`endif

  typedef struct {
    int level;
    int busy;
    int pwm;
    int flg;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  exp_t e;
  int   n_checks;
  int   n_fail;
  int   n_pushed;
  int   n_popped;

  // Behavioural model: brightness moves toward the request one step per StepDiv cycles.
  int m_level, m_moving, m_up, m_since, m_pwm_cnt, m_flg, m_h1, m_h2;

  blink_fader_if #(.PWM_BITS(PwmBits)) bus_if ();

  blink_fader #(
    .PWM_BITS(PwmBits),
    .STEP_DIV(StepDiv)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = 0; m_moving = 0; m_up = 0; m_since = 0;
    m_pwm_cnt = 0; m_flg = 0; m_h1 = 0; m_h2 = 0;
    exp_q.delete();
  endtask

  // Drive inputs for the coming rising edge and queue what the DUT must show after it.
  task automatic apply(input int led, input int flg);
    int   led_s;
    exp_t x;
    bus_if.led_in = led[0];
    bus_if.flg_in = flg[0];
    led_s = (Lat == 0) ? led : m_h2;
    x.pwm = (m_level == Max) ? 1 : (m_level == 0) ? 0 : int'(m_pwm_cnt < m_level);
    m_pwm_cnt = (m_pwm_cnt + 1) % (Max + 1);
    if (flg != 0) m_flg = (m_flg + 1) % 65536;
    if (m_moving == 0) begin
      if ((led_s != 0) ? (m_level != Max) : (m_level != 0)) begin
        m_moving = 1; m_up = led_s; m_since = 0;
      end
    end else if (led_s != m_up) begin
      m_up = led_s; m_since = 0;
    end else begin
      m_since++;
      if (m_since == StepDiv) begin
        m_since = 0;
        if (m_up != 0) m_level = (m_level < Max) ? m_level + 1 : Max;
        else           m_level = (m_level > 0) ? m_level - 1 : 0;
        if (m_level == ((m_up != 0) ? Max : 0)) m_moving = 0;
      end
    end
    m_h2 = m_h1; m_h1 = led;
    x.level = m_level; x.busy = m_moving; x.flg = m_flg;
    exp_q.push_back(x);
    n_pushed++;
  endtask

  task automatic step(input int led, input int flg);
    @(negedge clk);
    apply(led, flg);
  endtask

  task automatic steps(input int n, input int led);
    for (int i = 0; i < n; i++) step(led, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: compare every queued expectation against the outputs just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_popped++;
      chk("level", int'(bus_if.level), e.level);
      chk("busy", int'(bus_if.busy), e.busy);
      chk("pwm_out", int'(bus_if.pwm_out), e.pwm);
      chk("flg_cnt", int'(bus_if.flg_cnt), e.flg);
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; n_pushed = 0; n_popped = 0;
    model_reset();
    rst = 1'b0;
    bus_if.led_in = 1'b0;
    bus_if.flg_in = 1'b0;

    // Reset held with inputs toggling: everything stays zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_level", int'(bus_if.level), 0);
      chk("rst_busy", int'(bus_if.busy), 0);
      chk("rst_pwm", int'(bus_if.pwm_out), 0);
      chk("rst_flg", int'(bus_if.flg_cnt), 0);
      @(negedge clk);
      bus_if.led_in = ~bus_if.led_in;
      bus_if.flg_in = ~bus_if.flg_in;
    end

    // Full ramp up from OFF; busy latency shows the request path delay.
    @(negedge clk);
    rst = 1'b1;
    apply(1, 0);
    after_edge();
    chk("busy_latency", int'(bus_if.busy), (Lat == 0) ? 1 : 0);
    steps(1020 + Lat, 1);
    after_edge();
    chk("ramp_up_level", int'(bus_if.level), Max);
    chk("ramp_up_busy", int'(bus_if.busy), 0);
    steps(10, 1);
    after_edge();
    chk("on_pwm", int'(bus_if.pwm_out), 1);

    // Full ramp down.
    steps(1025 + Lat, 0);
    after_edge();
    chk("ramp_down_level", int'(bus_if.level), 0);
    chk("ramp_down_busy", int'(bus_if.busy), 0);

    // Reversal at level 100: holds for StepDiv cycles, then counts down.
    steps(401 + Lat, 1);
    after_edge();
    chk("rev_start_level", int'(bus_if.level), 100);
    steps(4 + Lat, 0);
    after_edge();
    chk("rev_hold_level", int'(bus_if.level), 100);
    step(0, 0);
    after_edge();
    chk("rev_first_step", int'(bus_if.level), 99);
    steps(400, 0);
    after_edge();
    chk("rev_end_level", int'(bus_if.level), 0);
    chk("rev_end_busy", int'(bus_if.busy), 0);

    // Asynchronous reset between edges mid-ramp.
    steps(201 + Lat, 1);
    @(posedge clk);
    #3;
    chk("pre_async_level", int'(bus_if.level), 50);
    rst = 1'b0;
    #1;
    chk("async_level", int'(bus_if.level), 0);
    chk("async_busy", int'(bus_if.busy), 0);
    chk("async_pwm", int'(bus_if.pwm_out), 0);
    chk("async_flg", int'(bus_if.flg_cnt), 0);
    model_reset();

    // Strobe counting with a back-to-back pair.
    @(negedge clk);
    rst = 1'b1;
    apply(0, 1);
    step(0, 1);
    step(0, 0);
    step(0, 1);
    after_edge();
    chk("flg_three", int'(bus_if.flg_cnt), 3);

    // Random request segments, short ones forcing mid-ramp reversals.
    for (int s = 0; s < 16; s++) begin
      int len;
      int led;
      len = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 500));
      led = int'($urandom_range(0, 1));
      for (int i = 0; i < len; i++) step(led, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    // Top the strobe count up to exactly 65536 so it wraps to zero.
    begin
      int need;
      need = 65536 - m_flg;
      for (int i = 0; i < need; i++) step(int'($urandom_range(0, 1)), 1);
    end
    after_edge();
    chk("flg_wrap", int'(bus_if.flg_cnt), 0);

    step(0, 0);
    after_edge();
    chk("scoreboard_drain", n_popped, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blink_fader.md
BLINK_FADER -- requirements
Module: blink_fader

Interface
REQ-001 SHALL have parameter PWM_BITS, default 8, brightness/PWM resolution in bits.
REQ-002 SHALL have parameter STEP_DIV, default 16, clock cycles per brightness step during a ramp (>=1).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port led_in  input  1  on/off request level from the upstream blinker.
REQ-006 SHALL have port flg_in  input  1  single-cycle period-boundary strobe from the upstream blinker.
REQ-007 SHALL have port pwm_out  output  1  registered PWM drive to the LED pin.
REQ-008 SHALL have port level  output  PWM_BITS  current brightness.
REQ-009 SHALL have port busy  output  1  high while a ramp is in progress.
REQ-010 SHALL have port flg_cnt  output  16  count of flg_in strobes since reset.

Function
REQ-011 SHALL implement a four-state FSM: OFF, RAMP_UP, ON, RAMP_DOWN.
REQ-012 OFF: level=0; led_s=1 -> RAMP_UP on the next edge.
REQ-013 RAMP_UP: level+1 per step tick; the edge on which level becomes MAX (2^PWM_BITS-1) also moves the FSM to ON.
REQ-014 ON: level=MAX; led_s=0 -> RAMP_DOWN on the next edge.
REQ-015 RAMP_DOWN: level-1 per step tick; the edge on which level becomes 0 also moves the FSM to OFF.
REQ-016 A request reversal mid-ramp (led_s=0 in RAMP_UP, or led_s=1 in RAMP_DOWN) SHALL switch direction on the next edge from the current level, with no jump in level.
REQ-017 level SHALL saturate at 0 and MAX and never wrap.
REQ-018 Step prescaler: counts 0..STEP_DIV-1 only in ramp states; clears to 0 on every state entry, including a direction reversal.
REQ-019 Step tick: asserts when the prescaler equals STEP_DIV-1, giving one level step every STEP_DIV cycles.
REQ-020 Full ramp duration SHALL be MAX*STEP_DIV cycles.
REQ-021 led_s SHALL equal led_in, or the synchronised copy of led_in when REQ-032 applies.
REQ-022 busy SHALL be high exactly when the FSM is in RAMP_UP or RAMP_DOWN.
REQ-023 PWM counter: free-running 0..MAX, wraps to 0.
REQ-024 pwm_out SHALL register (pwm_cnt < level), except that level==MAX forces constant 1 and level==0 forces constant 0.
REQ-025 pwm_out SHALL have one cycle of latency from level.
REQ-026 flg_cnt SHALL increment on every cycle with flg_in=1, including back-to-back strobes, and SHALL wrap 0xFFFF -> 0.
REQ-027 flg_cnt SHALL be independent of the FSM and led_in.

Reset
REQ-028 rst=0 SHALL immediately, without waiting for clk, force state=OFF, level=0, pwm_out=0, busy=0, flg_cnt=0, PWM counter=0, prescaler=0, and synchroniser flops=0.
REQ-029 Reset asserted mid-ramp SHALL abandon the ramp; there is no fade-out.
REQ-030 After rst returns high, the first state change SHALL occur on the first rising clk edge.

Configuration
REQ-031 Macro BLINK_FADER_SYNC_EN SHALL control input synchronisation of led_in.
REQ-032 With BLINK_FADER_SYNC_EN defined: led_s is led_in through a two-flop synchroniser, adding 2 cycles of latency from led_in to the FSM.
REQ-033 Without BLINK_FADER_SYNC_EN: led_s = led_in directly; the FSM reacts on the first edge after led_in changes.
REQ-034 flg_in SHALL never be synchronised; it is a same-clock strobe in both builds.

Verification
REQ-035 Reset: rst=0 at time 0 for 3 cycles, inputs toggling -> pwm_out=0, level=0, busy=0, flg_cnt=0 throughout.
REQ-036 Full ramp up (PWM_BITS=8, STEP_DIV=4, no macro): led_in=1 from OFF -> busy=1 next edge; level=255 after 1020 further cycles; then state ON, busy=0, pwm_out constant 1.
REQ-037 Reversal: led_in->0 while RAMP_UP at level=100 -> level holds 100 for 4 cycles, then reads 99, and decrements every 4 cycles to 0; then busy=0.
REQ-038 flg counting: 3 flg_in strobes, two of them back-to-back -> flg_cnt=3; 65536 strobes total -> flg_cnt=0.
REQ-039 Async reset mid-ramp: rst=0 between clock edges at level=50 -> level=0 and busy=0 before the next clk edge.
REQ-040 Sync latency: led_in rises from OFF -> busy rises on the 1st edge without BLINK_FADER_SYNC_EN and on the 3rd edge with it.
